// File: rtl/wisc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wisc_pkg
// Description : Shared constants for the fetch stage (FSM encoding, opcodes).
// Revision    : 1.0 - initial release
// ============================================================================
package wisc_pkg;

  localparam logic [1:0] ST_REQ     = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;
  localparam logic [1:0] ST_HALTED  = 2'd3;

  localparam logic [3:0]  OPC_HLT          = 4'hF;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] NOP_INSTR        = 16'h0000;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_reg
// Description : Program counter with write enable and redirect mux; bit 0 is
//               forced to zero on every load.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_reg #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wen,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic [ADDR_W-1:0] i_next_pc,
  output logic [ADDR_W-1:0] o_pc
);

  localparam logic [ADDR_W-1:0] c_EVEN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= RESET_PC & c_EVEN_MASK;
    end else if (i_redirect) begin
      r_pc <= i_redirect_pc & c_EVEN_MASK;
    end else if (i_wen) begin
      r_pc <= i_next_pc & c_EVEN_MASK;
    end
  end

  assign o_pc = r_pc;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC, imem request/valid handshake, IF/ID
//               register. Optional HLT stop enabled by macro FETCH_HALT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
  import wisc_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_wen,
  input  logic               if_id_wen,
  input  logic               if_id_flush,
  input  logic               control_hazard,
  input  logic [ADDR_W-1:0]  branch_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc2,
  output logic               if_id_valid,
  output logic               fetch_busy,
  output logic               halted
);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic               r_first;
  logic [INSTR_W-1:0] r_hold_instr;
  logic [ADDR_W-1:0]  w_pc;
  logic [ADDR_W-1:0]  w_pc_plus2;
  logic [INSTR_W-1:0] w_load_instr;
  logic               w_valid;
  logic               w_advance;
  logic               w_load;
  logic               w_capture_hold;
  logic               w_is_hlt;
  logic               w_pc_wen;

  // A return in the first cycle out of reset belongs to an abandoned request.
  assign w_valid      = imem_valid & ~r_first;
  assign w_advance    = if_id_wen & pc_wen;
  assign w_pc_plus2   = w_pc + ADDR_W'(2);
  assign w_load_instr = (r_state == ST_HOLD) ? r_hold_instr : imem_rdata;
  assign w_pc_wen     = w_load & ~w_is_hlt;
  assign imem_addr    = w_pc;

`ifdef FETCH_HALT_EN
  assign w_is_hlt = (w_load_instr[INSTR_W-1 -: 4] == OPC_HLT);
  assign halted   = (r_state == ST_HALTED);
`else
  assign w_is_hlt = 1'b0;
  assign halted   = 1'b0;
`endif

  pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .i_wen         (w_pc_wen),
    .i_redirect    (control_hazard),
    .i_redirect_pc (branch_pc),
    .i_next_pc     (w_pc_plus2),
    .o_pc          (w_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_REQ;
      r_first <= 1'b1;
    end else begin
      r_state <= w_next_state;
      r_first <= 1'b0;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (control_hazard) begin
      w_next_state = ((r_state == ST_REQ || r_state == ST_DISCARD) && !w_valid)
                     ? ST_DISCARD : ST_REQ;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_load)              w_next_state = w_is_hlt ? ST_HALTED : ST_REQ;
          else if (w_capture_hold) w_next_state = ST_HOLD;
        end
        ST_HOLD: begin
          if (w_load) w_next_state = w_is_hlt ? ST_HALTED : ST_REQ;
        end
        ST_DISCARD: begin
          if (w_valid) w_next_state = ST_REQ;
        end
        default: w_next_state = r_state;
      endcase
    end
  end

  always_comb begin
    imem_req       = 1'b0;
    fetch_busy     = 1'b0;
    w_load         = 1'b0;
    w_capture_hold = 1'b0;
    case (r_state)
      ST_REQ: begin
        imem_req       = rst;
        fetch_busy     = ~imem_valid;
        w_load         = w_valid & w_advance & ~control_hazard;
        w_capture_hold = w_valid & ~w_advance & ~control_hazard;
      end
      ST_HOLD: begin
        w_load = w_advance & ~control_hazard;
      end
      ST_DISCARD: begin
        fetch_busy = 1'b1;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_instr <= '0;
    end else if (w_capture_hold) begin
      r_hold_instr <= imem_rdata;
    end
  end

  // When ID consumes and nothing new arrived, a bubble is inserted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc2   <= '0;
    end else if (if_id_flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= INSTR_W'(NOP_INSTR);
    end else if (control_hazard) begin
      if_id_valid <= 1'b0;
    end else if (w_load) begin
      if_id_valid <= 1'b1;
      if_id_instr <= w_load_instr;
      if_id_pc2   <= w_pc_plus2;
    end else if (if_id_wen) begin
      if_id_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire
